// File: rtl/rps_round_referee.sv
// Player-side round controller for the rock-paper-scissors predictor.
// Synchronises PLAY, judges each round, strobes commit and keeps the score.
module rps_round_referee #(
   parameter int unsigned SETTLE     = 4,
   parameter int unsigned WIN_TARGET = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       play_n,
   input  logic [1:0] user,
   input  logic [1:0] ai_choice,
   output logic       commit,
   output logic [1:0] user_move,
   output logic [1:0] result,
   output logic [7:0] user_score,
   output logic [7:0] ai_score,
   output logic [7:0] rounds,
   output logic       busy,
   output logic       bad_move,
   output logic       game_over
);

   localparam logic [1:0] MV_ROCK     = 2'b00;
   localparam logic [1:0] MV_SCISSORS = 2'b01;
   localparam logic [1:0] MV_PAPER    = 2'b10;
   localparam logic [1:0] MV_BAD      = 2'b11;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_USER = 2'b01;
   localparam logic [1:0] RES_AI   = 2'b10;
   localparam logic [1:0] RES_TIE  = 2'b11;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [8:0] TARGET      = 9'(WIN_TARGET);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_JUDGE,
      S_COMMIT,
      S_RELEASE,
      S_OVER
   } state_t;

   state_t state, state_nx;

   function automatic logic [1:0] judge(
      input logic [1:0] u,
      input logic [1:0] a
   );
      logic [1:0] r;
      r = RES_AI;
      if (u == MV_BAD)
         r = RES_NONE;
      else if (u == a)
         r = RES_TIE;
      else if (a == MV_BAD)
         r = RES_USER;
      else if ((u == MV_ROCK     && a == MV_SCISSORS) ||
               (u == MV_SCISSORS && a == MV_PAPER)    ||
               (u == MV_PAPER    && a == MV_ROCK))
         r = RES_USER;
      return r;
   endfunction

   // Key path: capture flop plus two synchronisers, all idling high.
   logic       key_q;
   logic       sync_1;
   logic       sync_2;
   logic       sync_2_d;
   logic [2:0] fill;
   logic       armed;
   logic       press;

   always_ff @(posedge clock) begin
      if (reset) begin
         key_q    <= 1'b1;
         sync_1   <= 1'b1;
         sync_2   <= 1'b1;
         sync_2_d <= 1'b1;
         fill     <= '0;
         armed    <= 1'b0;
      end else begin
         key_q    <= play_n;
         sync_1   <= key_q;
         sync_2   <= sync_1;
         sync_2_d <= sync_2;
         fill     <= {fill[1:0], 1'b1};
         // Only a released key, seen after the reset values flushed, arms.
         if (fill[2] && sync_2)
            armed <= 1'b1;
      end
   end

   assign press = armed && !sync_2 && sync_2_d;

   logic [3:0] settle_cnt;
   logic [1:0] ai_move;
   logic [1:0] round_res;
   logic       user_hit;
   logic       ai_hit;
   logic       win_hit;

   assign round_res = judge(user_move, ai_move);
   assign user_hit  = ({1'b0, user_score} + 9'd1) == TARGET;
   assign ai_hit    = ({1'b0, ai_score} + 9'd1) == TARGET;
   assign win_hit   = (round_res == RES_USER && user_hit) ||
                      (round_res == RES_AI   && ai_hit);

   always_ff @(posedge clock) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (press)
               state_nx = S_SAMPLE;
         S_SAMPLE:
            if (settle_cnt == SETTLE_LAST)
               state_nx = S_JUDGE;
         S_JUDGE:
            if (user == MV_BAD)
               state_nx = S_RELEASE;
            else
               state_nx = S_COMMIT;
         S_COMMIT:
            if (win_hit)
               state_nx = S_OVER;
            else
               state_nx = S_RELEASE;
         S_RELEASE:
            if (sync_2)
               state_nx = S_IDLE;
         S_OVER:
            state_nx = S_OVER;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         settle_cnt <= '0;
         user_move  <= MV_ROCK;
         ai_move    <= MV_ROCK;
         result     <= RES_NONE;
         commit     <= 1'b0;
         bad_move   <= 1'b0;
         user_score <= '0;
         ai_score   <= '0;
         rounds     <= '0;
      end else begin
         commit   <= 1'b0;
         bad_move <= 1'b0;

         if (state == S_IDLE)
            settle_cnt <= '0;
         else if (state == S_SAMPLE)
            settle_cnt <= settle_cnt + 4'd1;

         if (state == S_JUDGE) begin
            user_move <= user;
            ai_move   <= ai_choice;
            result    <= judge(user, ai_choice);
            if (user == MV_BAD)
               bad_move <= 1'b1;
            else
               commit <= 1'b1;
         end

         if (state == S_COMMIT) begin
            if (rounds != 8'hFF)
               rounds <= rounds + 8'd1;
            if (round_res == RES_USER)
               user_score <= user_score + 8'd1;
            if (round_res == RES_AI)
               ai_score <= ai_score + 8'd1;
         end
      end
   end

   assign busy      = !(state == S_IDLE || state == S_OVER);
   assign game_over = (state == S_OVER);

endmodule

// File: doc/rps_round_referee.md
# rps_round_referee

Round controller on the player side of the rock-paper-scissors predictor. It synchronises the player's PLAY key and samples the player's switch move. It then samples the predictor's `choice` once that output has settled, and judges the round. It issues the one-cycle update strobe the predictor consumes, and keeps the match score that the top level shows on LEDR and HEX.

## Interface
Parameters:
- `SETTLE`, 4: cycles spent in SAMPLE before the predictor's combinational `choice` is captured. Range 1..15.
- `WIN_TARGET`, 5: score at which a side wins the match. Range 1..255.

Ports:
- `clock`, in, 1: the only clock. Top level connects CLOCK_50.
- `reset`, in, 1: synchronous, active-high. Clears all state.
- `play_n`, in, 1: raw PLAY key, active-low, asynchronous to `clock`.
- `user`, in, 2: player move from SW[1:0]. 00 rock, 01 scissors, 10 paper, 11 invalid.
- `ai_choice`, in, 2: predictor move, same encoding.
- `commit`, out, 1: one-cycle strobe telling the predictor to record `user_move` and advance its history.
- `user_move`, out, 2: latched player move. Stable from JUDGE until the next round's JUDGE.
- `result`, out, 2: last round outcome. 00 none, 01 player win, 10 AI win, 11 tie.
- `user_score`, out, 8: player round wins.
- `ai_score`, out, 8: AI round wins.
- `rounds`, out, 8: judged rounds, including ties.
- `busy`, out, 1: high in every state except IDLE and OVER.
- `bad_move`, out, 1: one-cycle pulse when a round is rejected because the move is invalid.
- `game_over`, out, 1: high in OVER.

## Operation
- Outputs after reset: `commit`, `bad_move`, `busy` and `game_over` = 0. `user_move` and `result` = 00. All counters = 0. FSM = IDLE.
- PLAY key handling:
  - `play_n` passes through two sync flops, both reset to 1.
  - `press` = stage-2 value is 0 while its delayed copy is 1.
- Winner relation: rock beats scissors, scissors beats paper, paper beats rock. Equal moves are a tie.
- FSM states:
  - IDLE: on `press`, go to SAMPLE and clear the settle counter.
  - SAMPLE: count to `SETTLE`, then go to JUDGE.
  - JUDGE: latch `user` into `user_move` and `ai_choice` into an internal register, and compute `result`.
    - If `user`=11: pulse `bad_move`, set `result`=00, go to RELEASE. No commit, no counter change.
    - Otherwise go to COMMIT.
  - COMMIT: `commit`=1 for exactly this cycle, then update counters:
    - `rounds` +1, saturating at 255.
    - On a player win, `user_score` +1. On an AI win, `ai_score` +1.
    - If the incremented score equals `WIN_TARGET`, go to OVER; otherwise go to RELEASE.
  - RELEASE: wait until sync stage 2 = 1, then go to IDLE.
  - OVER: ignore `press` and hold all outputs. Only `reset` leaves this state.
- An `ai_choice` of 11 in JUDGE is treated as a loss for the AI when the player move is valid. This keeps the rule defined, although the predictor should never produce 11.
- A `press` in any state other than IDLE is ignored. At most one round is judged per key press, however long the key is held.
- Reset mid-round abandons the round with no `commit`. A key held low across reset does not start a round until it is released and pressed again.

## Timing
- Let `play_n` first meet setup low at edge k, after being high.
  - Stage 2 is low from edge k+2, so `press` is seen in the cycle after edge k+2.
  - FSM enters SAMPLE at edge k+3.
  - FSM enters JUDGE at edge k+3+SETTLE.
  - `user_move`, `result` and `bad_move` are registered at edge k+4+SETTLE; FSM enters COMMIT at that edge.
  - `commit` is high in cycle [k+4+SETTLE, k+5+SETTLE).
  - Counters and `game_over` change at edge k+5+SETTLE.
- `user` and `ai_choice` are sampled only at edge k+4+SETTLE. Changes on either input at any other time have no effect.
- When `commit` is high, the predictor samples `user_move` on the same edge that ends the COMMIT cycle.
- Minimum round period: SETTLE+5 cycles plus the key release time.

## Test plan
- Reset, then `user`=00 and `ai_choice`=10, one press with SETTLE=4: `commit` is high exactly 8 cycles after the first low sample of `play_n`. Afterwards `result`=10, `ai_score`=1, `user_score`=0, `rounds`=1.
- `user`=01 and `ai_choice`=10: `result`=01, `user_score`+1. With `user`=10 and `ai_choice`=10: `result`=11, only `rounds`+1.
- `user`=11: `bad_move` pulses once, `commit` never goes high, all counters unchanged, `result`=00.
- Hold `play_n` low for 1000 cycles: exactly one `commit`. Toggling `ai_choice` during SAMPLE changes nothing except the value captured at the JUDGE edge.
- With WIN_TARGET=5, player wins 5 rounds: `game_over` rises at the fifth COMMIT edge with `user_score`=5. A sixth press produces no `commit` and no counter change.
- Assert `reset` for one cycle during SAMPLE: no `commit`, all outputs return to their reset values, FSM is IDLE. With `play_n` still low, no round starts until the key is released and pressed again.
